// File: rtl/timestamp_pkg.sv
// -----------------------------------------------------------------------------
// timestamp_pkg
//   Shared defaults and types for the timestamp event counter block.
//   TS_CNT_WIDTH / TS_NUM_CMP / TS_CAP_DEPTH are the default parameter values
//   used by timestamp_event_counter; ts_t is the default-width timestamp type
//   and CAP_AW the matching capture FIFO address width.
// -----------------------------------------------------------------------------
package timestamp_pkg;

  localparam int unsigned TS_CNT_WIDTH = 64;
  localparam int unsigned TS_NUM_CMP   = 4;
  localparam int unsigned TS_CAP_DEPTH = 8;
  localparam int unsigned CAP_AW       = $clog2(TS_CAP_DEPTH);

  typedef logic [TS_CNT_WIDTH-1:0] ts_t;

  // Number of bits needed to hold an occupancy of 0..depth inclusive.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ts_capture_fifo.sv
// -----------------------------------------------------------------------------
// ts_capture_fifo
//   Synchronous FIFO holding captured timestamps, with a sticky overflow flag.
//   A trigger pushes push_data; when the FIFO is full the entry is dropped and
//   overflow is set, unless the head is popped in the same cycle (then both the
//   pop and the push are accepted). No bypass: a push into an empty FIFO only
//   becomes visible on the following cycle.
// Ports
//   clk             in   clock, rising edge
//   reset           in   synchronous active-high reset, empties FIFO
//   trig            in   push request
//   push_data       in   W  value to store on push
//   pop_ready       in   consumer ready; pop when valid & pop_ready
//   overflow_clear  in   clears the sticky overflow flag
//   head_data       out  W  head entry (zero while empty)
//   head_valid      out  FIFO non-empty
//   overflow        out  sticky drop indicator
// -----------------------------------------------------------------------------
module ts_capture_fifo
  import timestamp_pkg::*;
#(
  parameter int unsigned W     = TS_CNT_WIDTH,
  parameter int unsigned DEPTH = TS_CAP_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         trig,
  input  logic [W-1:0] push_data,
  input  logic         pop_ready,
  input  logic         overflow_clear,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = occ_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full_s, empty_s, pop_s, push_s, drop_s;

  assign full_s  = (count_q == FULL_CNT);
  assign empty_s = (count_q == {CW{1'b0}});
  assign pop_s   = !empty_s && pop_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s  = trig && (!full_s || pop_s);
  assign drop_s  = trig && full_s && !pop_s;

  // Pointer, occupancy and sticky-overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
    // A new drop wins over a simultaneous clear.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; contents are masked while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_valid = !empty_s;
  assign head_data  = empty_s ? {W{1'b0}} : mem_q[rd_ptr_q];
  assign overflow   = overflow_q;

endmodule

// File: rtl/timestamp_event_counter.sv
// -----------------------------------------------------------------------------
// timestamp_event_counter
//   Free-running timestamp counter with offset load and wrap pulse, NUM_CMP
//   one-shot compare channels, and a capture FIFO that timestamps triggers.
// Ports
//   clk, reset                        clock / synchronous active-high reset
//   start                             count enable (+1 per cycle)
//   counter_offset, offset_en         load value / load strobe (beats start)
//   counter, wrap                     current count / 1-cycle wrap pulse
//   cmp_value, cmp_arm                per-channel compare value / arm strobe
//   cmp_armed, cmp_hit                per-channel armed status / hit pulse
//   capture_trig                      push current count into capture FIFO
//   cap_data, cap_valid, cap_ready    FIFO head / non-empty / consumer ready
//   cap_overflow, overflow_clear      sticky drop flag / its clear
// -----------------------------------------------------------------------------
module timestamp_event_counter
  import timestamp_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = TS_CNT_WIDTH,
  parameter int unsigned NUM_CMP   = TS_NUM_CMP,
  parameter int unsigned CAP_DEPTH = TS_CAP_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [CNT_WIDTH-1:0]         counter_offset,
  input  logic                         offset_en,
  output logic [CNT_WIDTH-1:0]         counter,
  output logic                         wrap,
  input  logic [NUM_CMP*CNT_WIDTH-1:0] cmp_value,
  input  logic [NUM_CMP-1:0]           cmp_arm,
  output logic [NUM_CMP-1:0]           cmp_armed,
  output logic [NUM_CMP-1:0]           cmp_hit,
  input  logic                         capture_trig,
  output logic [CNT_WIDTH-1:0]         cap_data,
  output logic                         cap_valid,
  input  logic                         cap_ready,
  output logic                         cap_overflow,
  input  logic                         overflow_clear
);

  localparam logic [CNT_WIDTH-1:0] ALL_ONES = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] counter_q, counter_d;
  logic                 wrap_q, wrap_d;

  // Counter next-state: offset load beats increment; only an increment from
  // all-ones reports a wrap, so loading zero never pulses wrap.
  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    if (offset_en) begin
      counter_d = counter_offset;
      wrap_d    = 1'b0;
    end else if (start) begin
      counter_d = counter_q + ONE;
      wrap_d    = (counter_q == ALL_ONES);
    end else begin
      counter_d = counter_q;
      wrap_d    = 1'b0;
    end
  end

  // Counter and wrap registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter_q <= {CNT_WIDTH{1'b0}};
      wrap_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
    end
  end

  assign counter = counter_q;
  assign wrap    = wrap_q;

  for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
    logic [CNT_WIDTH-1:0] val_q, val_d;
    logic                 armed_q, armed_d;
    logic                 hit_q, hit_d;
    logic                 match_s;

    // Equality only: a jump over the value never fires.
    assign match_s = armed_q && (counter_q == val_q);

    // Arming wins over the one-shot disarm, so a re-arm on the hit cycle
    // keeps the channel armed with the new value while the hit still issues.
    always_comb begin
      val_d   = val_q;
      armed_d = armed_q;
      hit_d   = match_s;
      if (cmp_arm[i]) begin
        val_d   = cmp_value[i*CNT_WIDTH +: CNT_WIDTH];
        armed_d = 1'b1;
      end else if (match_s) begin
        val_d   = val_q;
        armed_d = 1'b0;
      end else begin
        val_d   = val_q;
        armed_d = armed_q;
      end
    end

    // Channel registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        val_q   <= {CNT_WIDTH{1'b0}};
        armed_q <= 1'b0;
        hit_q   <= 1'b0;
      end else begin
        val_q   <= val_d;
        armed_q <= armed_d;
        hit_q   <= hit_d;
      end
    end

    assign cmp_armed[i] = armed_q;
    assign cmp_hit[i]   = hit_q;
  end

  ts_capture_fifo #(
    .W     (CNT_WIDTH),
    .DEPTH (CAP_DEPTH)
  ) u_cap_fifo (
    .clk            (clk),
    .reset          (reset),
    .trig           (capture_trig),
    .push_data      (counter_q),
    .pop_ready      (cap_ready),
    .overflow_clear (overflow_clear),
    .head_data      (cap_data),
    .head_valid     (cap_valid),
    .overflow       (cap_overflow)
  );

endmodule

// File: tb/tb_timestamp_event_counter.sv
module tb_timestamp_event_counter;
  import timestamp_pkg::*;

  localparam int W = 64;
  localparam int N = 4;
  localparam int D = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   counter_offset = '0;
  logic           offset_en = 1'b0;
  logic [W-1:0]   counter;
  logic           wrap;
  logic [N*W-1:0] cmp_value = '0;
  logic [N-1:0]   cmp_arm = '0;
  logic [N-1:0]   cmp_armed;
  logic [N-1:0]   cmp_hit;
  logic           capture_trig = 1'b0;
  logic [W-1:0]   cap_data;
  logic           cap_valid;
  logic           cap_ready = 1'b0;
  logic           cap_overflow;
  logic           overflow_clear = 1'b0;

  timestamp_event_counter dut (
    .clk(clk), .reset(reset), .start(start), .counter_offset(counter_offset),
    .offset_en(offset_en), .counter(counter), .wrap(wrap), .cmp_value(cmp_value),
    .cmp_arm(cmp_arm), .cmp_armed(cmp_armed), .cmp_hit(cmp_hit),
    .capture_trig(capture_trig), .cap_data(cap_data), .cap_valid(cap_valid),
    .cap_ready(cap_ready), .cap_overflow(cap_overflow), .overflow_clear(overflow_clear)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: behavioural state described directly from the rules.
  ts_t        m_cnt = '0;
  logic       m_wrap = 1'b0;
  ts_t        m_val [N];
  logic [N-1:0] m_armed = '0;
  logic [N-1:0] m_hit = '0;
  ts_t        m_q [$];
  logic       m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("counter",   counter,         m_cnt);
    chk("wrap",      W'(wrap),        W'(m_wrap));
    chk("cmp_armed", W'(cmp_armed),   W'(m_armed));
    chk("cmp_hit",   W'(cmp_hit),     W'(m_hit));
    chk("cap_valid", W'(cap_valid),   W'(m_q.size() != 0));
    chk("cap_data",  cap_data,        (m_q.size() != 0) ? m_q[0] : ts_t'(0));
    chk("cap_ovf",   W'(cap_overflow), W'(m_ovf));
  endtask

  // Advance one clock: update model from the inputs seen at this edge, then check.
  task automatic tick();
    ts_t n_cnt;
    logic n_wrap;
    logic [N-1:0] n_hit;
    bit full_now, pop_now;
    n_hit = '0;
    if (reset) begin
      n_cnt = '0; n_wrap = 1'b0;
      m_armed = '0;
      for (int i = 0; i < N; i++) m_val[i] = '0;
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      n_cnt  = offset_en ? counter_offset : (start ? m_cnt + ts_t'(1) : m_cnt);
      n_wrap = !offset_en && start && (m_cnt == '1);
      for (int i = 0; i < N; i++) begin
        n_hit[i] = m_armed[i] && (m_cnt == m_val[i]);
        if (cmp_arm[i]) begin
          m_armed[i] = 1'b1;
          m_val[i]   = cmp_value[i*W +: W];
        end else if (n_hit[i]) begin
          m_armed[i] = 1'b0;
        end
      end
      full_now = (m_q.size() == D);
      pop_now  = (m_q.size() != 0) && cap_ready;
      if (pop_now) void'(m_q.pop_front());
      if (capture_trig) begin
        if (!full_now || pop_now) m_q.push_back(m_cnt);
        else m_ovf = 1'b1;
      end
      if (overflow_clear && !(capture_trig && full_now && !pop_now)) m_ovf = 1'b0;
    end
    @(posedge clk);
    m_cnt = n_cnt; m_wrap = n_wrap; m_hit = n_hit;
    #1;
    check_all();
    reset = 1'b0; offset_en = 1'b0; cmp_arm = '0; capture_trig = 1'b0; overflow_clear = 1'b0;
  endtask

  task automatic arm(input int ch, input ts_t v);
    cmp_arm[ch] = 1'b1;
    cmp_value[ch*W +: W] = v;
  endtask

  task automatic wait_hit(input int ch, input int budget, input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if (cmp_hit[ch]) seen = 1'b1;
    end
    chk({tag, "_seen"}, W'(seen), W'(1));
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_val[i] = '0;
    #1;
    // 1: reset, count 10, hold 3
    reset = 1'b1; tick();
    chk("rst_counter", counter, 64'd0);
    start = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    chk("count10", counter, 64'd10);
    start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("hold10", counter, 64'd10);

    // 2: wrap from all-ones
    counter_offset = 64'hFFFF_FFFF_FFFF_FFFE; offset_en = 1'b1; start = 1'b1; tick();
    chk("load_fe", W'(wrap), 64'd0);
    tick();
    chk("at_ff", counter, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap_zero", counter, 64'd0);
    chk("wrap_pulse", W'(wrap), 64'd1);
    tick();
    chk("wrap_gone", W'(wrap), 64'd0);
    counter_offset = 64'd0; offset_en = 1'b1; start = 1'b0; tick();
    chk("load0_nowrap", W'(wrap), 64'd0);

    // 3: two channels in flight, then offset jump over an armed value
    reset = 1'b1; start = 1'b0; tick();
    arm(0, 64'd100); arm(1, 64'd50); start = 1'b1; tick();
    wait_hit(1, 80, "hit1");
    chk("hit1_at", counter, 64'd51);
    chk("hit1_disarm", W'(cmp_armed[1]), 64'd0);
    wait_hit(0, 80, "hit0");
    chk("hit0_at", counter, 64'd101);
    start = 1'b0; counter_offset = 64'd40; offset_en = 1'b1; tick();
    arm(2, 64'd100); tick();
    counter_offset = 64'd200; offset_en = 1'b1; tick();
    start = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("jump_nohit", W'(cmp_hit[2]), 64'd0);
    chk("jump_armed", W'(cmp_armed[2]), 64'd1);

    // 4: re-arm on the hit cycle
    counter_offset = 64'd290; offset_en = 1'b1; arm(0, 64'd295); tick();
    for (int k = 0; k < 20 && m_cnt != 64'd295; k++) tick();
    arm(0, 64'd300); tick();
    chk("rearm_hit", W'(cmp_hit[0]), 64'd1);
    chk("rearm_armed", W'(cmp_armed[0]), 64'd1);
    wait_hit(0, 20, "hit300");
    chk("hit300_at", counter, 64'd301);

    // 5: overflow with 9 captures, drain in order, clear
    reset = 1'b1; tick();
    cap_ready = 1'b0; counter_offset = 64'd10; offset_en = 1'b1; tick();
    start = 1'b1;
    for (int k = 0; k < 9; k++) begin capture_trig = 1'b1; tick(); end
    start = 1'b0;
    chk("ovf_set", W'(cap_overflow), 64'd1);
    cap_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_data", cap_data, 64'd10 + 64'(k));
      tick();
    end
    chk("drained", W'(cap_valid), 64'd0);
    cap_ready = 1'b0; overflow_clear = 1'b1; tick();
    chk("ovf_clr", W'(cap_overflow), 64'd0);

    // 6: full FIFO with simultaneous pop/push, then reset mid-fill
    start = 1'b1;
    for (int k = 0; k < 8; k++) begin capture_trig = 1'b1; tick(); end
    capture_trig = 1'b1; cap_ready = 1'b1; tick();
    cap_ready = 1'b0;
    chk("full_popush_ovf", W'(cap_overflow), 64'd0);
    chk("full_count", 64'(m_q.size()), 64'd8);
    capture_trig = 1'b1; overflow_clear = 1'b1; tick();
    chk("set_beats_clr", W'(cap_overflow), 64'd1);
    arm(3, m_cnt + 64'd50); tick();
    reset = 1'b1; tick();
    chk("rst_valid", W'(cap_valid), 64'd0);
    chk("rst_armed", W'(cmp_armed), 64'd0);

    // Randomised traffic against the model
    for (int k = 0; k < 400; k++) begin
      start = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        offset_en = 1'b1;
        counter_offset = ($urandom_range(0, 1) != 0) ? ts_t'(64'hFFFF_FFFF_FFFF_FFF8) + ts_t'($urandom_range(0, 7))
                                                     : ts_t'($urandom_range(0, 500));
      end
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) arm(i, m_cnt + ts_t'($urandom_range(0, 12)));
      capture_trig   = ($urandom_range(0, 2) == 0);
      cap_ready      = ($urandom_range(0, 1) != 0);
      overflow_clear = ($urandom_range(0, 9) == 0);
      reset          = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
